iobus_turnaround_ctrl: RTL and testbench

Sequences a shared bidirectional external data bus built from tristate IO buffers (output data, active-high tristate enable, input data). It arbitrates between one write requester and one read requester and drives the buffer's T control so the bus is never driven by both ends. It generates the external strobe and direction signals and enforces setup, strobe and turnaround timing. It sits between a PicoBlaze port decoder and the IOBUF pad ring.

---
 rtl/iobus_turnaround_ctrl_if.sv | 31 +++
 rtl/iobus_turnaround_ctrl.sv | 168 ++++++++++++++++
 tb/tb_iobus_turnaround_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iobus_turnaround_ctrl_if.sv
// rtl/iobus_turnaround_ctrl_if.sv - request/response and pad-side signals of the IO bus turnaround controller
//
// Requester side: wr_req/wr_data/wr_ack, rd_req/rd_data/rd_valid, busy.
// Pad side:       pad_o/pad_t/pad_i to the IOBUF ring, strobe_n/rnw to the external device.
// slave  = controller view, master = requester/pad view.
interface iobus_turnaround_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             wr_req;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ack;
    logic             rd_req;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             busy;
    logic [WIDTH-1:0] pad_o;
    logic             pad_t;
    logic [WIDTH-1:0] pad_i;
    logic             strobe_n;
    logic             rnw;

    modport slave (
        input  wr_req, wr_data, rd_req, pad_i,
        output wr_ack, rd_data, rd_valid, busy, pad_o, pad_t, strobe_n, rnw
    );

    modport master (
        output wr_req, wr_data, rd_req, pad_i,
        input  wr_ack, rd_data, rd_valid, busy, pad_o, pad_t, strobe_n, rnw
    );
endinterface

// File: rtl/iobus_turnaround_ctrl.sv
// rtl/iobus_turnaround_ctrl.sv - sequences a shared tristate data bus between one writer and one reader
//
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - iobus_turnaround_ctrl_if.slave (requests, responses, IOBUF and strobe/direction pins)
module iobus_turnaround_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int TURN_CYC   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    iobus_turnaround_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_STROBE,
        S_W_HOLD,
        S_R_STROBE,
        S_TURN
    } state_t;

    // Counter holds "cycles remaining after this one" so the exit test is cnt == 0.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] TURN_LD   = 8'(TURN_CYC - 1);

    state_t           state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic             last_rd, last_rd_nxt;   // 1 when the most recent grant was a read
    logic             accept_wr;
    logic             capture_rd;
    logic [WIDTH-1:0] pad_o_q;
    logic [WIDTH-1:0] rd_data_q;

    logic pad_t_c, strobe_n_c, rnw_c, wr_ack_c, rd_valid_c, busy_c;

    // State register plus the datapath registers it qualifies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            last_rd   <= 1'b1;
            pad_o_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last_rd <= last_rd_nxt;
            if (accept_wr) begin
                pad_o_q <= bus.wr_data;
            end
            if (capture_rd) begin
                rd_data_q <= bus.pad_i;
            end
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_rd_nxt = last_rd;
        accept_wr   = 1'b0;
        capture_rd  = 1'b0;
        case (state)
            S_IDLE: begin
                // With both requests pending, alternate against the last grant.
                if (bus.wr_req && (!bus.rd_req || last_rd)) begin
                    state_nxt   = S_W_SETUP;
                    cnt_nxt     = SETUP_LD;
                    accept_wr   = 1'b1;
                    last_rd_nxt = 1'b0;
                end else if (bus.rd_req) begin
                    state_nxt   = S_R_STROBE;
                    cnt_nxt     = STROBE_LD;
                    last_rd_nxt = 1'b1;
                end
            end
            S_W_SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_W_STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_W_STROBE: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_W_HOLD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_W_HOLD: begin
                state_nxt = S_IDLE;
            end
            S_R_STROBE: begin
                if (cnt == 8'd0) begin
                    state_nxt  = S_TURN;
                    cnt_nxt    = TURN_LD;
                    capture_rd = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_TURN: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state; the bus is driven only during the write states.
    always_comb begin
        pad_t_c    = 1'b1;
        strobe_n_c = 1'b1;
        rnw_c      = 1'b1;
        wr_ack_c   = 1'b0;
        rd_valid_c = 1'b0;
        busy_c     = (state != S_IDLE);
        case (state)
            S_W_SETUP: begin
                pad_t_c = 1'b0;
                rnw_c   = 1'b0;
            end
            S_W_STROBE: begin
                pad_t_c    = 1'b0;
                rnw_c      = 1'b0;
                strobe_n_c = 1'b0;
            end
            S_W_HOLD: begin
                pad_t_c  = 1'b0;
                rnw_c    = 1'b0;
                wr_ack_c = 1'b1;
            end
            S_R_STROBE: begin
                strobe_n_c = 1'b0;
            end
            S_TURN: begin
                // Counter still equals its load value only in the first TURN cycle.
                rd_valid_c = (cnt == TURN_LD);
            end
            default: begin
            end
        endcase
    end

    assign bus.pad_t    = pad_t_c;
    assign bus.strobe_n = strobe_n_c;
    assign bus.rnw      = rnw_c;
    assign bus.wr_ack   = wr_ack_c;
    assign bus.rd_valid = rd_valid_c;
    assign bus.busy     = busy_c;
    assign bus.pad_o    = pad_o_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_iobus_turnaround_ctrl.sv
// tb/tb_iobus_turnaround_ctrl.sv - directed self-checking bench for iobus_turnaround_ctrl
`timescale 1ns/1ps

module tb_iobus_turnaround_ctrl;

    logic clk = 1'b0;
    logic rst1;
    logic rst2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    iobus_turnaround_ctrl_if #(.WIDTH(8)) bus1();
    iobus_turnaround_ctrl_if #(.WIDTH(8)) bus2();

    iobus_turnaround_ctrl #(
        .WIDTH(8), .SETUP_CYC(1), .STROBE_CYC(2), .TURN_CYC(2)
    ) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    iobus_turnaround_ctrl #(
        .WIDTH(8), .SETUP_CYC(3), .STROBE_CYC(4), .TURN_CYC(1)
    ) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int since;
        int order [3];
        logic rearm_wr;
        logic rearm_rd;
        int first_drive;
        int ack_at;
        int val_at;

        rst1 = 1'b1;
        rst2 = 1'b1;
        bus1.wr_req = 1'b0; bus1.rd_req = 1'b0; bus1.wr_data = 8'h00; bus1.pad_i = 8'h00;
        bus2.wr_req = 1'b0; bus2.rd_req = 1'b0; bus2.wr_data = 8'h00; bus2.pad_i = 8'h00;
        tick();
        tick();

        chk("rst_pad_t",    bus1.pad_t,    1'b1);
        chk("rst_strobe_n", bus1.strobe_n, 1'b1);
        chk("rst_rnw",      bus1.rnw,      1'b1);
        chk("rst_pad_o",    bus1.pad_o,    8'h00);
        chk("rst_rd_data",  bus1.rd_data,  8'h00);
        chk("rst_wr_ack",   bus1.wr_ack,   1'b0);
        chk("rst_rd_valid", bus1.rd_valid, 1'b0);
        chk("rst_busy",     bus1.busy,     1'b0);

        rst1 = 1'b0;
        rst2 = 1'b0;
        bus1.wr_data = 8'hA5;
        bus1.wr_req  = 1'b1;
        tick();
        chk("w1_c1_pad_t",    bus1.pad_t,    1'b0);
        chk("w1_c1_strobe_n", bus1.strobe_n, 1'b1);
        chk("w1_c1_rnw",      bus1.rnw,      1'b0);
        chk("w1_c1_busy",     bus1.busy,     1'b1);
        bus1.wr_data = 8'hFF;
        tick();
        chk("w1_c2_pad_t",    bus1.pad_t,    1'b0);
        chk("w1_c2_strobe_n", bus1.strobe_n, 1'b0);
        chk("w1_c2_pad_o",    bus1.pad_o,    8'hA5);
        tick();
        chk("w1_c3_pad_t",    bus1.pad_t,    1'b0);
        chk("w1_c3_strobe_n", bus1.strobe_n, 1'b0);
        chk("w1_c3_wr_ack",   bus1.wr_ack,   1'b0);
        tick();
        chk("w1_c4_wr_ack",   bus1.wr_ack,   1'b1);
        chk("w1_c4_pad_t",    bus1.pad_t,    1'b0);
        chk("w1_c4_strobe_n", bus1.strobe_n, 1'b1);
        bus1.wr_req = 1'b0;
        tick();
        chk("w1_c5_pad_t",    bus1.pad_t,    1'b1);
        chk("w1_c5_busy",     bus1.busy,     1'b0);
        chk("w1_c5_wr_ack",   bus1.wr_ack,   1'b0);
        chk("w1_c5_pad_o",    bus1.pad_o,    8'hA5);

        bus1.pad_i  = 8'h3C;
        bus1.rd_req = 1'b1;
        tick();
        chk("r1_c1_strobe_n", bus1.strobe_n, 1'b0);
        chk("r1_c1_rnw",      bus1.rnw,      1'b1);
        chk("r1_c1_pad_t",    bus1.pad_t,    1'b1);
        tick();
        chk("r1_c2_strobe_n", bus1.strobe_n, 1'b0);
        chk("r1_c2_rd_valid", bus1.rd_valid, 1'b0);
        tick();
        chk("r1_c3_rd_valid", bus1.rd_valid, 1'b1);
        chk("r1_c3_rd_data",  bus1.rd_data,  8'h3C);
        chk("r1_c3_strobe_n", bus1.strobe_n, 1'b1);
        chk("r1_c3_pad_t",    bus1.pad_t,    1'b1);
        bus1.rd_req = 1'b0;
        bus1.pad_i  = 8'h00;
        tick();
        chk("r1_c4_rd_valid", bus1.rd_valid, 1'b0);
        chk("r1_c4_rd_data",  bus1.rd_data,  8'h3C);
        chk("r1_c4_busy",     bus1.busy,     1'b1);
        chk("r1_c4_pad_t",    bus1.pad_t,    1'b1);
        tick();
        chk("r1_c5_busy",     bus1.busy,     1'b0);

        n = 0;
        since = 99;
        rearm_wr = 1'b0;
        rearm_rd = 1'b0;
        bus1.wr_data = 8'h11;
        bus1.pad_i   = 8'h22;
        bus1.wr_req  = 1'b1;
        bus1.rd_req  = 1'b1;
        for (int c = 0; c < 60 && n < 3; c++) begin
            tick();
            if (rearm_wr) begin bus1.wr_req = 1'b1; rearm_wr = 1'b0; end
            if (rearm_rd) begin bus1.rd_req = 1'b1; rearm_rd = 1'b0; end
            if (!bus1.strobe_n && bus1.rnw) since = 0;
            else if (since < 99) since++;
            if (!bus1.pad_t) chk("arb_turnaround", (since > 2), 1'b1);
            if (bus1.wr_ack) begin
                order[n] = 0; n++;
                bus1.wr_req = 1'b0; rearm_wr = 1'b1;
            end
            if (bus1.rd_valid) begin
                order[n] = 1; n++;
                bus1.rd_req = 1'b0; rearm_rd = 1'b1;
            end
        end
        bus1.wr_req = 1'b0;
        bus1.rd_req = 1'b0;
        chk("arb_count",        n,        3);
        chk("arb_first_write",  order[0], 0);
        chk("arb_second_read",  order[1], 1);
        chk("arb_third_write",  order[2], 0);
        tick();
        tick();
        chk("arb_idle", bus1.busy, 1'b0);

        bus1.pad_i  = 8'h96;
        bus1.rd_req = 1'b1;
        tick();
        tick();
        chk("rw_c2_strobe_n", bus1.strobe_n, 1'b0);
        tick();
        chk("rw_c3_strobe_n", bus1.strobe_n, 1'b1);
        chk("rw_c3_rd_valid", bus1.rd_valid, 1'b1);
        chk("rw_c3_rd_data",  bus1.rd_data,  8'h96);
        bus1.rd_req  = 1'b0;
        bus1.wr_data = 8'h5A;
        bus1.wr_req  = 1'b1;
        first_drive = -1;
        ack_at = -1;
        for (int k = 1; k <= 20 && ack_at < 0; k++) begin
            tick();
            if (!bus1.pad_t && first_drive < 0) first_drive = k;
            if (bus1.wr_ack) begin
                ack_at = k;
                bus1.wr_req = 1'b0;
            end
        end
        chk("rw_drive_delay", first_drive, 3);
        chk("rw_write_done",  (ack_at > 0), 1'b1);
        chk("rw_pad_o",       bus1.pad_o, 8'h5A);
        tick();

        bus1.wr_data = 8'hC3;
        bus1.wr_req  = 1'b1;
        tick();
        tick();
        tick();
        chk("ab_strobe2", bus1.strobe_n, 1'b0);
        rst1 = 1'b1;
        tick();
        chk("ab_pad_t",    bus1.pad_t,    1'b1);
        chk("ab_strobe_n", bus1.strobe_n, 1'b1);
        chk("ab_wr_ack",   bus1.wr_ack,   1'b0);
        chk("ab_busy",     bus1.busy,     1'b0);
        rst1 = 1'b0;
        ack_at = -1;
        for (int k = 1; k <= 20 && ack_at < 0; k++) begin
            tick();
            if (bus1.wr_ack) begin
                ack_at = k;
                bus1.wr_req = 1'b0;
            end
        end
        chk("ab_retry_ack_at", ack_at, 4);
        chk("ab_retry_pad_o",  bus1.pad_o, 8'hC3);

        bus2.wr_data = 8'h4B;
        bus2.wr_req  = 1'b1;
        ack_at = -1;
        for (int k = 1; k <= 30 && ack_at < 0; k++) begin
            tick();
            if (bus2.wr_ack) begin
                ack_at = k;
                bus2.wr_req = 1'b0;
            end
        end
        chk("p_write_ack_at", ack_at, 8);
        chk("p_write_pad_o",  bus2.pad_o, 8'h4B);
        tick();
        chk("p_write_idle", bus2.busy, 1'b0);
        bus2.pad_i  = 8'hE7;
        bus2.rd_req = 1'b1;
        val_at = -1;
        for (int k = 1; k <= 30 && val_at < 0; k++) begin
            tick();
            if (bus2.rd_valid) begin
                val_at = k;
                bus2.rd_req = 1'b0;
            end
        end
        chk("p_read_valid_at", val_at, 5);
        chk("p_read_data",     bus2.rd_data, 8'hE7);
        tick();
        chk("p_read_idle",     bus2.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
